// File: rtl/divider_pkg.sv
// Shared definitions for the divider lanes and their controller.
// Holds the lane FSM encoding, default operand widths and lane count.
// No logic; imported by every divider file.
package divider_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ITER = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam int DIV_NUM_W = 16;
    localparam int DIV_DEN_W = 16;
    localparam int DIV_LANES = 8;

endpackage

// File: rtl/divider_lane_if.sv
// Controller-to-lane bundle: start pulse with operands, results and status levels.
// Purely wiring; no latency of its own.
// No backpressure: the lane ignores starts while busy, the controller watches div_done.
interface divider_lane_if
    import divider_pkg::*;
#(
    parameter int NUM_W = DIV_NUM_W,
    parameter int DEN_W = DIV_DEN_W
) ();

    logic             div_en;
    logic [NUM_W-1:0] numerator;
    logic [DEN_W-1:0] denominator;
    logic [NUM_W-1:0] quotient;
    logic [DEN_W-1:0] remainder;
    logic             div_done;
    logic             div_busy;
    logic             div_by_zero;

    // Controller side
    modport master (
        output div_en, numerator, denominator,
        input  quotient, remainder, div_done, div_busy, div_by_zero
    );

    // Lane side
    modport slave (
        input  div_en, numerator, denominator,
        output quotient, remainder, div_done, div_busy, div_by_zero
    );

endinterface

// File: rtl/divider_lane.sv
// Unsigned restoring divider lane: one quotient bit per clock.
// Latency NUM_W cycles from the accepted div_en edge to div_done, operand independent.
// div_en is ignored while iterating; results hold in DONE until the next accepted start.
module divider_lane
    import divider_pkg::*;
#(
    parameter int NUM_W = DIV_NUM_W,
    parameter int DEN_W = DIV_DEN_W
) (
    input  logic          clk,
    input  logic          reset,
    divider_lane_if.slave lane
);

    localparam int CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [NUM_W-1:0] r_num;      // numerator shifting out, quotient shifting in
    logic [DEN_W-1:0] r_den;
    logic [DEN_W:0]   r_rem;      // partial remainder
    logic [CNT_W-1:0] r_cnt;
    logic             r_dbz;

    logic             w_accept;
    logic [DEN_W:0]   w_trial;
    logic             w_ge;
    logic [DEN_W:0]   w_rem_nxt;
    logic             w_last;

    assign w_accept = lane.div_en && (r_state != DIV_ITER);
    assign w_last   = (r_cnt == '0);

    // Restoring step: shift in the next numerator bit, subtract if it fits.
    // A set top remainder bit means the trial already exceeds any DEN_W-bit divisor.
    assign w_trial   = {r_rem[DEN_W-1:0], r_num[NUM_W-1]};
    assign w_ge      = r_rem[DEN_W] || (w_trial >= {1'b0, r_den});
    assign w_rem_nxt = w_ge ? (w_trial - {1'b0, r_den}) : w_trial;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start from IDLE/DONE, finish when the counter reaches zero
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE, DIV_DONE: begin
                if (w_accept) begin
                    w_state_nxt = DIV_ITER;
                end
            end
            DIV_ITER: begin
                if (w_last) begin
                    w_state_nxt = DIV_DONE;
                end
            end
            default: w_state_nxt = DIV_IDLE;
        endcase
    end

    // Datapath: load operands on accept, iterate one bit per cycle while in ITER
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num <= '0;
            r_den <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_num <= lane.numerator;
            r_den <= lane.denominator;
            r_rem <= '0;
            r_cnt <= CNT_W'(NUM_W - 1);
            r_dbz <= 1'b0;
        end else if (r_state == DIV_ITER) begin
            r_num <= {r_num[NUM_W-2:0], w_ge};
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_dbz <= (r_den == '0);
            end
        end
    end

    assign lane.quotient    = r_num;
    assign lane.remainder   = r_rem[DEN_W-1:0];
    assign lane.div_done    = (r_state == DIV_DONE);
    assign lane.div_busy    = (r_state == DIV_ITER);
    assign lane.div_by_zero = r_dbz;

endmodule
